// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for timer_ctrl_master: timer slave register map, control bits, FSM states.
// The snapshot states exist only when TIMER_CTRL_SNAPSHOT_EN is defined.
package timer_ctrl_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_RUN,
    ST_CLR_ST,
    ST_WR_STOP
`ifdef TIMER_CTRL_SNAPSHOT_EN
    ,
    ST_SNAP_WR,
    ST_SNAP_RDL,
    ST_SNAP_RDH,
    ST_SNAP_CAP
`endif
  } state_t;

  function automatic logic [15:0] ctrl_run_word(input logic cont);
    logic [15:0] w;
    w             = '0;
    w[CTRL_ITO]   = 1'b1;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = 1'b1;
    return w;
  endfunction

  function automatic logic [15:0] ctrl_stop_word();
    logic [15:0] w;
    w            = '0;
    w[CTRL_STOP] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs the interval timer and turns each acknowledged timeout into a tick.
// Define TIMER_CTRL_SNAPSHOT_EN to also read back the snapshot registers after every timeout.
module timer_ctrl_master
  import timer_ctrl_pkg::*;
#(
  parameter int TICK_CNT_W = 16,
  parameter bit CONT_MODE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           cfg_period,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic                  timer_irq,
  output logic [2:0]            avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write_n,
  output logic [15:0]           avm_writedata,
  input  logic [15:0]           avm_readdata,
  output logic                  busy,
  output logic                  running,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count
`ifdef TIMER_CTRL_SNAPSHOT_EN
  ,
  output logic [31:0]           snap_value,
  output logic                  snap_valid
`endif
);

  localparam logic [15:0] CTRL_RUN  = ctrl_run_word(CONT_MODE);
  localparam logic [15:0] CTRL_STOP = ctrl_stop_word();

  state_t                r_state;
  logic [31:0]           r_per;
  logic                  r_stop_pend;
  logic                  r_running;
  logic                  r_tick;
  logic [TICK_CNT_W-1:0] r_tick_count;
  logic                  r_cs;
  logic                  r_wn;
  logic [2:0]            r_addr;
  logic [15:0]           r_wdata;
  logic                  w_busy;

`ifdef TIMER_CTRL_SNAPSHOT_EN
  logic [31:0]           r_snap_value;
  logic                  r_snap_valid;
`else
  logic                  w_unused_rd;
  assign w_unused_rd = ^avm_readdata;
`endif

  assign w_busy = (r_state != ST_IDLE) && (r_state != ST_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_per        <= '0;
      r_stop_pend  <= 1'b0;
      r_running    <= 1'b0;
      r_tick       <= 1'b0;
      r_tick_count <= '0;
      r_cs         <= 1'b0;
      r_wn         <= 1'b1;
      r_addr       <= ADDR_STATUS;
      r_wdata      <= '0;
`ifdef TIMER_CTRL_SNAPSHOT_EN
      r_snap_value <= '0;
      r_snap_valid <= 1'b0;
`endif
    end else begin
      // Bus returns to idle unless the next state issues an access.
      r_cs    <= 1'b0;
      r_wn    <= 1'b1;
      r_addr  <= ADDR_STATUS;
      r_wdata <= '0;
      r_tick  <= 1'b0;
`ifdef TIMER_CTRL_SNAPSHOT_EN
      r_snap_valid <= 1'b0;
`endif
      // A stop during any sequence is remembered and served from RUN.
      if (cfg_stop && w_busy)
        r_stop_pend <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (cfg_start && !cfg_stop) begin
            r_per   <= cfg_period;
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_addr  <= ADDR_PERIOD_L;
            r_wdata <= cfg_period[15:0];
            r_state <= ST_WR_PL;
          end
        end
        ST_WR_PL: begin
          r_cs    <= 1'b1;
          r_wn    <= 1'b0;
          r_addr  <= ADDR_PERIOD_H;
          r_wdata <= r_per[31:16];
          r_state <= ST_WR_PH;
        end
        ST_WR_PH: begin
          r_cs    <= 1'b1;
          r_wn    <= 1'b0;
          r_addr  <= ADDR_CONTROL;
          r_wdata <= CTRL_RUN;
          r_state <= ST_WR_CTRL;
        end
        ST_WR_CTRL: begin
          r_running <= 1'b1;
          r_state   <= ST_RUN;
        end
        ST_RUN: begin
          if (cfg_stop || r_stop_pend) begin
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_addr  <= ADDR_CONTROL;
            r_wdata <= CTRL_STOP;
            r_state <= ST_WR_STOP;
          end else if (cfg_start) begin
            r_per   <= cfg_period;
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_addr  <= ADDR_PERIOD_L;
            r_wdata <= cfg_period[15:0];
            r_state <= ST_WR_PL;
          end else if (timer_irq) begin
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_addr  <= ADDR_STATUS;
            r_wdata <= '0;
            r_state <= ST_CLR_ST;
          end
        end
        ST_CLR_ST: begin
          r_tick       <= 1'b1;
          r_tick_count <= r_tick_count + TICK_CNT_W'(1);
`ifdef TIMER_CTRL_SNAPSHOT_EN
          r_cs    <= 1'b1;
          r_wn    <= 1'b0;
          r_addr  <= ADDR_SNAP_L;
          r_wdata <= '0;
          r_state <= ST_SNAP_WR;
`else
          r_state <= ST_RUN;
`endif
        end
        ST_WR_STOP: begin
          r_running   <= 1'b0;
          r_stop_pend <= 1'b0;
          r_state     <= ST_IDLE;
        end
`ifdef TIMER_CTRL_SNAPSHOT_EN
        ST_SNAP_WR: begin
          r_cs    <= 1'b1;
          r_addr  <= ADDR_SNAP_L;
          r_state <= ST_SNAP_RDL;
        end
        ST_SNAP_RDL: begin
          r_cs    <= 1'b1;
          r_addr  <= ADDR_SNAP_H;
          r_state <= ST_SNAP_RDH;
        end
        ST_SNAP_RDH: begin
          // Read data for the low-half read arrives one cycle late.
          r_snap_value[15:0] <= avm_readdata;
          r_state            <= ST_SNAP_CAP;
        end
        ST_SNAP_CAP: begin
          r_snap_value[31:16] <= avm_readdata;
          r_snap_valid        <= 1'b1;
          r_state             <= ST_RUN;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_wn;
  assign avm_address    = r_addr;
  assign avm_writedata  = r_wdata;
  assign busy           = w_busy;
  assign running        = r_running;
  assign tick           = r_tick;
  assign tick_count     = r_tick_count;
`ifdef TIMER_CTRL_SNAPSHOT_EN
  assign snap_value     = r_snap_value;
  assign snap_valid     = r_snap_valid;
`endif

endmodule
